// File: rtl/gba_save_sd.sv
// gba_save_sd: moves the GBA cartridge backup RAM between a byte-wide
// dual-port BRAM and the mounted save image, acting as the initiator on
// the hps_io virtual-SD sector interface.
//
// Ports:
//   clk_sys, reset          system clock, async active-high reset
//   img_mounted/readonly/   image mount pulse, read-only flag and size;
//   img_size                the sector count is latched at the mount pulse
//   save_req                pulse: write backup RAM back to the image
//   cpu_save_we             gba_top wrote backup RAM (marks it dirty)
//   sd_lba/sd_rd/sd_wr      sector request to hps_io
//   sd_ack, sd_buff_*       hps_io transfer handshake and byte stream
//   bram_*                  byte-wide port into the backup RAM
//   busy/loaded/save_done   status: transfer active, save valid, save finished
module gba_save_sd #(
    parameter int SAVE_SECTORS = 256,
    parameter int ADDR_W       = 17
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    input  logic              save_req,
    input  logic              cpu_save_we,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wdata,
    output logic              bram_we,
    input  logic [7:0]        bram_rdata,
    output logic              busy,
    output logic              loaded,
    output logic              save_done
);

    localparam int SW = ADDR_W - 9;
    localparam logic [SW:0]   MAX_N = (SW+1)'(SAVE_SECTORS);
    localparam logic [SW:0]   ONE_N = (SW+1)'(1);
    localparam logic [SW-1:0] ONE_S = SW'(1);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER, NEXT
    } state_t;

    state_t state, state_nx;

    logic [SW-1:0]     sector;
    logic [SW:0]       n_sect;
    logic [SW:0]       n_new;
    logic [31:0]       img_sects;
    logic [ADDR_W-1:0] wr_addr;
    logic              pend_load, pend_save, dirty, dir_wr, last;
    logic              take_load, take_save, sec_clr, sec_inc;
    logic              set_loaded, clr_loaded, done_nx, clr_dirty;
    logic              unused_size;

    // Partial trailing sectors are ignored; oversized images are clamped.
    assign img_sects   = img_size[40:9];
    assign unused_size = ^{img_size[63:41], img_size[8:0]};
    assign n_new = (img_sects > 32'(SAVE_SECTORS)) ? MAX_N : img_sects[SW:0];
    assign last  = ({1'b0, sector} == n_sect - ONE_N);

    assign sd_lba      = 32'(sector);
    assign sd_rd       = (state == RD_REQ);
    assign sd_wr       = (state == WR_REQ);
    assign busy        = (state != IDLE);
    assign sd_buff_din = bram_rdata;

    // Saves read the BRAM straight from hps_io's byte index; loads use the
    // address registered alongside the write data.
    assign bram_addr = (state == WR_REQ || state == WR_XFER)
                     ? {sector, sd_buff_addr} : wr_addr;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        take_load  = 1'b0;
        take_save  = 1'b0;
        sec_clr    = 1'b0;
        sec_inc    = 1'b0;
        set_loaded = 1'b0;
        clr_loaded = 1'b0;
        done_nx    = 1'b0;
        clr_dirty  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_load) begin
                    take_load  = 1'b1;
                    clr_loaded = 1'b1;
                    sec_clr    = 1'b1;
                    if (n_sect != '0) state_nx = RD_REQ;
                end else if (pend_save) begin
                    take_save = 1'b1;
                    if (n_sect == '0 || img_readonly || !dirty) begin
                        done_nx = 1'b1;
                    end else begin
                        sec_clr   = 1'b1;
                        clr_dirty = 1'b1;
                        state_nx  = WR_REQ;
                    end
                end
            end
            RD_REQ:  if (sd_ack)  state_nx = RD_XFER;
            RD_XFER: if (!sd_ack) state_nx = NEXT;
            WR_REQ:  if (sd_ack)  state_nx = WR_XFER;
            WR_XFER: if (!sd_ack) state_nx = NEXT;
            NEXT: begin
                // A fresh mount abandons the remaining sectors.
                if (pend_load) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = IDLE;
                    if (dir_wr) done_nx    = 1'b1;
                    else        set_loaded = 1'b1;
                end else begin
                    sec_inc  = 1'b1;
                    state_nx = dir_wr ? WR_REQ : RD_REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sector     <= '0;
            n_sect     <= '0;
            pend_load  <= 1'b0;
            pend_save  <= 1'b0;
            dirty      <= 1'b0;
            dir_wr     <= 1'b0;
            loaded     <= 1'b0;
            save_done  <= 1'b0;
            bram_we    <= 1'b0;
            bram_wdata <= '0;
            wr_addr    <= '0;
        end else begin
            // New events win over the clear of the same cycle.
            pend_load <= img_mounted | (pend_load & ~take_load);
            pend_save <= save_req | (pend_save & ~take_save);
            dirty     <= cpu_save_we | (dirty & ~clr_dirty);
            if (img_mounted) n_sect <= n_new;
            if (sec_clr)      sector <= '0;
            else if (sec_inc) sector <= sector + ONE_S;
            if (state == IDLE) dir_wr <= (state_nx == WR_REQ);
            if (set_loaded)      loaded <= 1'b1;
            else if (clr_loaded) loaded <= 1'b0;
            save_done <= done_nx;
            bram_we   <= (state == RD_XFER) && sd_buff_wr;
            if ((state == RD_XFER) && sd_buff_wr) begin
                wr_addr    <= {sector, sd_buff_addr};
                bram_wdata <= sd_buff_dout;
            end
        end
    end

endmodule

// File: tb/tb_gba_save_sd.sv
// Testbench for gba_save_sd: hps_io responder model, backup RAM model and
// a request/byte scoreboard. Geometry is scaled to 8 sectors of 512 bytes.
module tb_gba_save_sd;

    localparam int SECT = 8;
    localparam int AW   = 12;
    localparam logic [63:0] SZ_1M = 64'd1048576;
    localparam logic [63:0] SZ_3K = 64'd3072;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          img_mounted;
    logic          img_readonly;
    logic [63:0]   img_size;
    logic          save_req;
    logic          cpu_save_we;
    logic [31:0]   sd_lba;
    logic          sd_rd;
    logic          sd_wr;
    logic          sd_ack;
    logic [8:0]    sd_buff_addr;
    logic [7:0]    sd_buff_dout;
    logic          sd_buff_wr;
    logic [7:0]    sd_buff_din;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_wdata;
    logic          bram_we;
    logic [7:0]    bram_rdata;
    logic          busy;
    logic          loaded;
    logic          save_done;

    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    int         exp_req[$];
    logic [7:0] exp_byte[$];
    logic [7:0] mem [0:(1<<AW)-1];

    always #5 clk_sys = ~clk_sys;

    gba_save_sd #(.SAVE_SECTORS(SECT), .ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size(img_size), .save_req(save_req),
        .cpu_save_we(cpu_save_we), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_we(bram_we), .bram_rdata(bram_rdata),
        .busy(busy), .loaded(loaded), .save_done(save_done)
    );

    // Dual-port backup RAM: DUT port plus the gba_top (CPU) port.
    always @(posedge clk_sys) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        if (cpu_we)  mem[cpu_addr]  <= cpu_data;
        bram_rdata <= mem[bram_addr];
    end

    always @(negedge clk_sys) if (save_done === 1'b1) done_cnt++;

    function automatic logic [7:0] pat(int lba, int i);
        return 8'(lba ^ i);
    endfunction

    // hps_io responder: serves one sector per request.
    task automatic serve();
        bit wr;
        bit abort;
        int lba;
        int code;
        int e;
        logic [7:0] eb;
        wr = sd_wr;
        lba = int'(sd_lba);
        abort = 1'b0;
        code = wr ? (32'h10000 | lba) : lba;
        checks++;
        if (exp_req.size() == 0) begin
            errors++;
            $display("FAIL req_seq: got req %0h, required none", code);
        end else begin
            e = exp_req.pop_front();
            if (code != e) begin
                errors++;
                $display("FAIL req_seq: got req %0h, required %0h", code, e);
            end
        end
        if (wr) wr_cnt++;
        else    rd_cnt++;
        sd_ack = 1'b1;
        @(negedge clk_sys);
        if (!reset) begin
            checks++;
            if ((wr ? sd_wr : sd_rd) !== 1'b0) begin
                errors++;
                $display("FAIL req_drop: got request still high, required 0");
            end
        end
        for (int i = 0; i < 512 && !abort; i++) begin
            sd_buff_addr = 9'(i);
            if (!wr) begin
                sd_buff_dout = pat(lba, i);
                sd_buff_wr = 1'b1;
                @(negedge clk_sys);
                sd_buff_wr = 1'b0;
            end else begin
                @(negedge clk_sys);
                @(negedge clk_sys);
                if (!reset) begin
                    checks++;
                    if (exp_byte.size() == 0) begin
                        errors++;
                        $display("FAIL wr_byte: got %h, required none",
                                 sd_buff_din);
                    end else begin
                        eb = exp_byte.pop_front();
                        if (sd_buff_din !== eb) begin
                            errors++;
                            $display("FAIL wr_byte lba %0d i %0d: got %h, required %h",
                                     lba, i, sd_buff_din, eb);
                        end
                    end
                end
            end
            if (reset) abort = 1'b1;
        end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
    endtask

    initial begin
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset && (sd_rd || sd_wr)) serve();
        end
    end

    task automatic push_rd(input int cnt);
        for (int s = 0; s < cnt; s++) exp_req.push_back(s);
    endtask

    task automatic push_wr(input int cnt, input bit cpu_mod);
        logic [7:0] b;
        for (int s = 0; s < cnt; s++) begin
            exp_req.push_back(32'h10000 | s);
            for (int i = 0; i < 512; i++) begin
                b = pat(s, i);
                if (cpu_mod && s == 0 && i == 3) b = 8'hA5;
                exp_byte.push_back(b);
            end
        end
    endtask

    task automatic pulse_mount(input logic [63:0] sz);
        img_size = sz;
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
    endtask

    // Returns at the second negedge after save_req rose.
    task automatic pulse_save();
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic pulse_dirty();
        cpu_save_we = 1'b1;
        @(negedge clk_sys);
        cpu_save_we = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        repeat (3) @(negedge clk_sys);
        for (int n = 0; n < 40000; n++) begin
            @(negedge clk_sys);
            if (!busy) quiet++;
            else       quiet = 0;
            if (quiet >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sector(input int lba, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk_sys);
            if (sd_ack && sd_lba == 32'(lba)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (sd_lba !== 32'd0) begin
            errors++; $display("FAIL rst_lba: got %0h, required 0", sd_lba);
        end
        checks++;
        if ({sd_rd, sd_wr, bram_we} !== 3'b000) begin
            errors++; $display("FAIL rst_req: got %b, required 000",
                               {sd_rd, sd_wr, bram_we});
        end
        checks++;
        if ({busy, loaded, save_done} !== 3'b000) begin
            errors++; $display("FAIL rst_status: got %b, required 000",
                               {busy, loaded, save_done});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_load_small();
        bit ok;
        int r0;
        int bad;
        r0 = rd_cnt;
        push_rd(6);
        pulse_mount(SZ_3K);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_small_to: got busy, required idle"); end
        checks++;
        if (exp_req.size() != 0 || rd_cnt - r0 != 6) begin
            errors++; $display("FAIL load_small_cnt: got %0d reads, required 6", rd_cnt - r0);
        end
        checks++;
        if (loaded !== 1'b1) begin errors++; $display("FAIL load_small_loaded: got %b, required 1", loaded); end
        for (int s = 0; s < 6; s++) begin
            bad = 0;
            for (int i = 0; i < 512; i++) if (mem[s*512+i] !== pat(s, i)) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL load_small_data sector %0d: got %0d bad bytes, required 0", s, bad);
            end
        end
    endtask

    task automatic test_load_clamp();
        bit ok;
        int r0;
        r0 = rd_cnt;
        push_rd(SECT);
        pulse_mount(SZ_1M);
        wait_idle(ok);
        checks++;
        if (!ok || exp_req.size() != 0 || rd_cnt - r0 != SECT) begin
            errors++; $display("FAIL clamp_cnt: got %0d reads, required %0d", rd_cnt - r0, SECT);
        end
        checks++;
        if (sd_lba !== 32'(SECT - 1)) begin
            errors++; $display("FAIL clamp_last_lba: got %0d, required %0d", sd_lba, SECT - 1);
        end
        checks++;
        if (loaded !== 1'b1) begin errors++; $display("FAIL clamp_loaded: got %b, required 1", loaded); end
    endtask

    task automatic test_save_clean();
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_save();
        checks++;
        if (save_done !== 1'b1) begin errors++; $display("FAIL clean_done: got %b, required 1", save_done); end
        repeat (4) @(negedge clk_sys);
        checks++;
        if (wr_cnt != w0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL clean_nowr: got %0d writes %0d dones, required 0 1",
                               wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_save_dirty();
        bit ok;
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        cpu_addr = AW'(3);
        cpu_data = 8'hA5;
        cpu_we = 1'b1;
        pulse_dirty();
        cpu_we = 1'b0;
        push_wr(SECT, 1'b1);
        pulse_save();
        wait_idle(ok);
        checks++;
        if (!ok || exp_req.size() != 0 || exp_byte.size() != 0) begin
            errors++; $display("FAIL dirty_seq: got %0d reqs %0d bytes left, required 0 0",
                               exp_req.size(), exp_byte.size());
        end
        checks++;
        if (wr_cnt - w0 != SECT || done_cnt - d0 != 1) begin
            errors++; $display("FAIL dirty_cnt: got %0d writes %0d dones, required %0d 1",
                               wr_cnt - w0, done_cnt - d0, SECT);
        end
        w0 = wr_cnt;
        pulse_save();
        checks++;
        if (save_done !== 1'b1) begin errors++; $display("FAIL resave_done: got %b, required 1", save_done); end
        repeat (4) @(negedge clk_sys);
        checks++;
        if (wr_cnt != w0) begin errors++; $display("FAIL resave_nowr: got %0d writes, required 0", wr_cnt - w0); end
    endtask

    task automatic test_save_readonly();
        int w0;
        w0 = wr_cnt;
        img_readonly = 1'b1;
        pulse_dirty();
        pulse_save();
        checks++;
        if (save_done !== 1'b1) begin errors++; $display("FAIL ro_done: got %b, required 1", save_done); end
        repeat (4) @(negedge clk_sys);
        checks++;
        if (wr_cnt != w0 || busy !== 1'b0) begin
            errors++; $display("FAIL ro_nowr: got %0d writes busy %b, required 0 0", wr_cnt - w0, busy);
        end
        img_readonly = 1'b0;
    endtask

    task automatic test_mount_midload();
        bit ok;
        int r0;
        int bad;
        r0 = rd_cnt;
        push_rd(6);
        push_rd(SECT);
        pulse_mount(SZ_1M);
        wait_sector(5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reach5: got timeout, required sector 5"); end
        repeat (20) @(negedge clk_sys);
        pulse_mount(SZ_1M);
        wait_idle(ok);
        checks++;
        if (!ok || exp_req.size() != 0 || rd_cnt - r0 != 6 + SECT) begin
            errors++; $display("FAIL mid_seq: got %0d reads, required %0d", rd_cnt - r0, 6 + SECT);
        end
        checks++;
        if (loaded !== 1'b1) begin errors++; $display("FAIL mid_loaded: got %b, required 1", loaded); end
        bad = 0;
        for (int a = 0; a < SECT*512; a++) if (mem[a] !== pat(a / 512, a % 512)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_data: got %0d bad bytes, required 0", bad); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int r0;
        int w0;
        int d0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_dirty();
        push_rd(6);
        push_wr(6, 1'b0);
        img_size = SZ_3K;
        img_mounted = 1'b1;
        save_req = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        save_req = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || exp_req.size() != 0 || exp_byte.size() != 0) begin
            errors++; $display("FAIL b2b_seq: got %0d reqs left, required 0", exp_req.size());
        end
        checks++;
        if (rd_cnt - r0 != 6 || wr_cnt - w0 != 6 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL b2b_cnt: got rd %0d wr %0d done %0d, required 6 6 1",
                               rd_cnt - r0, wr_cnt - w0, done_cnt - d0);
        end
        checks++;
        if (loaded !== 1'b1) begin errors++; $display("FAIL b2b_loaded: got %b, required 1", loaded); end
    endtask

    task automatic test_zero_size();
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        pulse_mount(64'd300);
        repeat (6) @(negedge clk_sys);
        checks++;
        if (busy !== 1'b0 || loaded !== 1'b0 || rd_cnt != r0) begin
            errors++; $display("FAIL zero_load: got busy %b loaded %b reads %0d, required 0 0 0",
                               busy, loaded, rd_cnt - r0);
        end
        pulse_dirty();
        pulse_save();
        checks++;
        if (save_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", save_done); end
        repeat (4) @(negedge clk_sys);
        checks++;
        if (wr_cnt != w0) begin errors++; $display("FAIL zero_nowr: got %0d writes, required 0", wr_cnt - w0); end
    endtask

    task automatic test_reset_midxfer();
        bit ok;
        int bad;
        push_rd(6);
        pulse_mount(SZ_3K);
        wait_sector(2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rx_reach2: got timeout, required sector 2"); end
        repeat (5) @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sd_rd, busy, loaded} !== 3'b000 || sd_lba !== 32'd0) begin
            errors++; $display("FAIL rx_async: got rd %b busy %b loaded %b lba %0d, required 0 0 0 0",
                               sd_rd, busy, loaded, sd_lba);
        end
        repeat (4) @(negedge clk_sys);
        exp_req.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        cpu_addr = AW'(2*512 + 7);
        cpu_data = 8'h00;
        cpu_we = 1'b1;
        @(negedge clk_sys);
        cpu_we = 1'b0;
        push_rd(6);
        pulse_mount(SZ_3K);
        wait_idle(ok);
        checks++;
        if (!ok || exp_req.size() != 0 || loaded !== 1'b1) begin
            errors++; $display("FAIL rx_reload: got %0d reqs left loaded %b, required 0 1",
                               exp_req.size(), loaded);
        end
        bad = 0;
        for (int a = 0; a < 6*512; a++) if (mem[a] !== pat(a / 512, a % 512)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rx_data: got %0d bad bytes, required 0", bad); end
    endtask

    initial begin
        reset = 1'b1;
        img_mounted = 1'b0;
        img_readonly = 1'b0;
        img_size = '0;
        save_req = 1'b0;
        cpu_save_we = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;
        repeat (3) @(negedge clk_sys);
        test_reset();
        test_load_small();
        test_load_clamp();
        test_save_clean();
        test_save_dirty();
        test_save_readonly();
        test_mount_midload();
        test_back_to_back();
        test_zero_size();
        test_reset_midxfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
